// File: rtl/limbus_sysid_checker.sv
// Reads the ID and timestamp words from an Avalon-MM sysid slave and compares
// them against the expected build values. Each read phase is bounded by a timeout.
module limbus_sysid_checker #(
  parameter logic [31:0] EXP_ID     = 32'd666,
  parameter logic [31:0] EXP_TS     = 32'd1354828801,
  parameter int          TIMEOUT    = 255,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] id_q,
  output logic [31:0] ts_q,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_flags
);

  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic [2:0] err;
  logic       auto_pend;
  logic       in_phase, got, tmo;

  assign in_phase = (state == ID_REQ) || (state == ID_WAIT) ||
                    (state == TS_REQ) || (state == TS_WAIT);
  assign got      = avm_readdatavalid && ((state == ID_WAIT) || (state == TS_WAIT));
  // A word arriving on the last allowed cycle still counts; otherwise the phase expires.
  assign tmo      = in_phase && (cnt == TMO_LAST) && !got;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start || auto_pend) state_nx = ID_REQ;
      ID_REQ:  if (tmo) state_nx = DONE; else if (!avm_waitrequest) state_nx = ID_WAIT;
      ID_WAIT: if (tmo) state_nx = DONE; else if (got) state_nx = TS_REQ;
      TS_REQ:  if (tmo) state_nx = DONE; else if (!avm_waitrequest) state_nx = TS_WAIT;
      TS_WAIT: if (tmo || got) state_nx = DONE;
      DONE:    if (start) state_nx = ID_REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    avm_read    = (state == ID_REQ) || (state == TS_REQ);
    avm_address = (state == TS_REQ);
    busy        = in_phase;
    done        = (state == DONE);
    pass        = (state == DONE) && (err == 3'b000);
    err_flags   = err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      err       <= '0;
      id_q      <= '0;
      ts_q      <= '0;
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      if (state_nx != state && (state_nx == ID_REQ || state_nx == TS_REQ))
        cnt <= '0;
      else if (in_phase)
        cnt <= cnt + 8'd1;
      if (state_nx == ID_REQ && state != ID_REQ)
        err <= '0;
      if (tmo)
        err[2] <= 1'b1;
      if (got && state == ID_WAIT) begin
        id_q   <= avm_readdata;
        err[0] <= (avm_readdata != EXP_ID);
      end
      if (got && state == TS_WAIT) begin
        ts_q   <= avm_readdata;
        err[1] <= (avm_readdata != EXP_TS);
      end
    end
  end

endmodule

// File: tb/tb_limbus_sysid_checker.sv
// Bench for limbus_sysid_checker: behavioural sysid slave plus an outcome/latency
// model derived from per-phase rules, directed corner cases and randomized checks.
module tb_limbus_sysid_checker;

  localparam int          T   = 16;
  localparam logic [31:0] EID = 32'd666;
  localparam logic [31:0] ETS = 32'd1354828801;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic        avm_address, avm_read, busy, done, pass;
  logic [31:0] id_q, ts_q;
  logic [2:0]  err_flags;
  logic        wr;
  logic        rdv = 1'b0;
  logic [31:0] rdata = '0;

  int vectors = 0, miscompares = 0, stab_viol = 0;

  logic [31:0] s_id = EID, s_ts = ETS;
  int          s_wait = 0, stall = 0;
  bit          s_drop_id = 0, s_drop_ts = 0;
  logic [31:0] m_id = '0, m_ts = '0;
  bit          hold = 0;
  logic        hold_addr = 1'b0;

  limbus_sysid_checker #(.EXP_ID(EID), .EXP_TS(ETS), .TIMEOUT(T), .AUTO_START(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(wr),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .id_q(id_q), .ts_q(ts_q), .busy(busy), .done(done), .pass(pass), .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  // Slave: stalls s_wait cycles per request, answers one cycle after acceptance.
  assign wr = avm_read && (stall < s_wait);

  always @(posedge clock) begin
    rdv <= 1'b0;
    if (avm_read && !wr) begin
      stall <= 0;
      if (!(avm_address ? s_drop_ts : s_drop_id)) begin
        rdv   <= 1'b1;
        rdata <= avm_address ? s_ts : s_id;
      end
    end else if (avm_read) stall <= stall + 1;
    else                   stall <= 0;
  end

  // A stalled request must keep read and address steady until accepted.
  always @(posedge clock) begin
    if (hold && !done && !reset && (!avm_read || avm_address != hold_addr))
      stab_viol = stab_viol + 1;
    hold      <= avm_read && wr;
    hold_addr <= avm_address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome: a phase completes iff the slave answers and stall+2 cycles fit in T.
  task automatic run_check(input bit auto_go, input string tag);
    bit         id_ok, ts_ok;
    int         len, n;
    logic [2:0] e;
    e     = 3'b000;
    id_ok = !s_drop_id && (s_wait + 2 <= T);
    ts_ok = !s_drop_ts && (s_wait + 2 <= T);
    if (!id_ok) begin
      e   = 3'b100;
      len = T;
    end else begin
      m_id = s_id;
      e[0] = (s_id != EID);
      len  = s_wait + 2;
      if (ts_ok) begin
        m_ts = s_ts;
        e[1] = (s_ts != ETS);
        len  = len + s_wait + 2;
      end else begin
        e[2] = 1'b1;
        len  = len + T;
      end
    end
    @(negedge clock);
    if (auto_go) reset = 1'b0; else start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_busy_on_entry"}, 32'(busy), 32'd1);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    chk({tag, "_err_cleared"}, 32'(err_flags), 32'd0);
    n = 0;
    while (!done && n < 300) begin
      @(posedge clock); #1;
      n++;
      if (!done) start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(len));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_flags), 32'(e));
    chk({tag, "_pass"}, 32'(pass), 32'(e == 3'b000));
    chk({tag, "_id_q"}, id_q, m_id);
    chk({tag, "_ts_q"}, ts_q, m_ts);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_id", id_q, 32'd0);
    chk("rst_ts", ts_q, 32'd0);

    run_check(1'b1, "auto");
    s_id = 32'd667;       run_check(1'b0, "id_bad");
    s_id = EID;           run_check(1'b0, "fixed");
    s_wait = 3;           run_check(1'b0, "stall3");
    s_wait = 0; s_drop_ts = 1; run_check(1'b0, "ts_tmo");
    s_drop_ts = 0; s_drop_id = 1; s_id = 32'd5; run_check(1'b0, "id_tmo");
    s_drop_id = 0; s_id = EID;
    s_wait = 14;          run_check(1'b0, "stall_edge");
    s_wait = 15;          run_check(1'b0, "stall_tmo");

    for (int i = 0; i < 16; i++) begin
      s_id      = ($urandom_range(0, 1) == 0) ? EID : $urandom;
      s_ts      = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
      s_wait    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 16)) : int'($urandom_range(0, 4));
      s_drop_id = ($urandom_range(0, 7) == 0);
      s_drop_ts = ($urandom_range(0, 7) == 0);
      run_check(1'b0, "rand");
    end

    // Abort in TS_WAIT with a response in flight, start pulsed while busy.
    s_id = 32'h1234; s_ts = ETS; s_wait = 0; s_drop_id = 0; s_drop_ts = 0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("abort_in_ts_wait", 32'(busy), 32'd1);
    chk("abort_id_captured", id_q, 32'h1234);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_read", 32'(avm_read), 32'd0);
    chk("abort_id", id_q, 32'd0);
    chk("abort_ts", ts_q, 32'd0);
    chk("abort_err", 32'(err_flags), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("abort_stray_id", id_q, 32'd0);
    m_id = '0; m_ts = '0;
    s_id = EID;
    run_check(1'b1, "post_rst");

    chk("req_stability", 32'(stab_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
